// File: rtl/alarm_pkg.sv
// Shared types for the alarm path: stamp type (also used by the BCD->stamp converter),
// day length and scheduler state encoding.
package alarm_pkg;

  typedef logic [63:0] stamp_t;

  localparam stamp_t SECS_PER_DAY = 64'd86400;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ARMED   = 3'd1,
    ST_RINGING = 3'd2,
    ST_SNOOZED = 3'd3,
    ST_CATCHUP = 3'd4
  } state_e;

endpackage

// File: rtl/alarm_sec_timer.sv
// Loadable seconds down-counter stepped by tick; zero flag plus a one-cycle expire
// strobe for the tick that takes the count from 1 to 0.
module alarm_sec_timer #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] load_val,
  input  logic         tick,
  output logic         zero,
  output logic         expire
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (tick && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero   = (cnt_q == '0);
  assign expire = tick && !load && (cnt_q == W'(1));

endmodule

// File: rtl/alarm_scheduler.sv
// Daily alarm sequencer: compares the target stamp with the seconds counter, rings,
// handles dismiss/timeout and re-arms one day later. Snooze built only with ALARM_SNOOZE_EN.
//
// state      | meaning
// IDLE       | alarm disabled or no target
// ARMED      | waiting for counter >= target_stamp
// RINGING    | ring high, ring timer running
// SNOOZED    | waiting for counter >= snooze stamp (ALARM_SNOOZE_EN only)
// CATCHUP    | advancing target_stamp by whole days until it lies in the future
module alarm_scheduler
  import alarm_pkg::*;
#(
  parameter int unsigned RING_SECS   = 60,
  parameter int unsigned SNOOZE_SECS = 300,
  parameter int unsigned MAX_SNOOZE  = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick_1hz,
  input  logic [63:0] counter,
  input  logic        alarm_set,
  input  logic [63:0] alarm_stamp,
  input  logic        alarm_en,
  input  logic        snooze,
  input  logic        dismiss,
  output logic        ring,
  output logic        armed,
  output logic [63:0] target_stamp,
  output logic [1:0]  snooze_cnt
);

  state_e     state_q, state_d;
  stamp_t     target_q, target_d;
  logic [1:0] snooze_cnt_q, snooze_cnt_d;
  logic       ring_q, ring_d;
  logic       armed_q, armed_d;
  logic       en_q;
  logic       timer_load, timer_zero, timer_expire;

`ifdef ALARM_SNOOZE_EN
  stamp_t snz_stamp_q, snz_stamp_d;
`else
  logic snooze_unused;
  assign snooze_unused = snooze ^ (SNOOZE_SECS != 0) ^ (MAX_SNOOZE != 0);
`endif

  alarm_sec_timer #(.W(32)) u_ring_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (timer_load),
    .load_val (32'(RING_SECS)),
    .tick     (tick_1hz),
    .zero     (timer_zero),
    .expire   (timer_expire)
  );

  always_comb begin
    state_d      = state_q;
    target_d     = target_q;
    snooze_cnt_d = snooze_cnt_q;
    timer_load   = 1'b0;
`ifdef ALARM_SNOOZE_EN
    snz_stamp_d  = snz_stamp_q;
`endif
    if (alarm_set) begin
      target_d     = alarm_stamp;
      snooze_cnt_d = 2'd0;
      state_d      = alarm_en ? ST_ARMED : ST_IDLE;
    end else if (!alarm_en) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!en_q && (target_q != '0)) state_d = ST_CATCHUP;
        end
        ST_ARMED: begin
          if (counter >= target_q) begin
            state_d    = ST_RINGING;
            timer_load = 1'b1;
          end
        end
        ST_RINGING: begin
          // zero covers a degenerate RING_SECS of 0; expire is the normal timeout
          if (dismiss || timer_expire || timer_zero) begin
            state_d = ST_CATCHUP;
`ifdef ALARM_SNOOZE_EN
          end else if (snooze && (snooze_cnt_q < 2'(MAX_SNOOZE))) begin
            snz_stamp_d  = counter + stamp_t'(SNOOZE_SECS);
            snooze_cnt_d = snooze_cnt_q + 2'd1;
            state_d      = ST_SNOOZED;
`endif
          end
        end
`ifdef ALARM_SNOOZE_EN
        ST_SNOOZED: begin
          if (dismiss) begin
            state_d = ST_CATCHUP;
          end else if (counter >= snz_stamp_q) begin
            state_d    = ST_RINGING;
            timer_load = 1'b1;
          end
        end
`endif
        ST_CATCHUP: begin
          snooze_cnt_d = 2'd0;
          if (target_q <= counter) begin
            target_d = target_q + SECS_PER_DAY;
          end else begin
            state_d = ST_ARMED;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    ring_d  = (state_d == ST_RINGING);
    armed_d = (state_d == ST_ARMED) || (state_d == ST_SNOOZED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      target_q     <= '0;
      snooze_cnt_q <= 2'd0;
      ring_q       <= 1'b0;
      armed_q      <= 1'b0;
      en_q         <= 1'b0;
`ifdef ALARM_SNOOZE_EN
      snz_stamp_q  <= '0;
`endif
    end else begin
      state_q      <= state_d;
      target_q     <= target_d;
      snooze_cnt_q <= snooze_cnt_d;
      ring_q       <= ring_d;
      armed_q      <= armed_d;
      en_q         <= alarm_en;
`ifdef ALARM_SNOOZE_EN
      snz_stamp_q  <= snz_stamp_d;
`endif
    end
  end

  assign ring         = ring_q;
  assign armed        = armed_q;
  assign target_stamp = target_q;
  assign snooze_cnt   = snooze_cnt_q;

endmodule

// File: tb/tb_alarm_scheduler.sv
// Bench for alarm_scheduler: directed scenarios then random traffic, all checked
// against a behavioural model of the alarm rules.
module tb_alarm_scheduler;

  localparam int RING = 60;
  localparam int SNZ  = 300;
  localparam int MAXS = 3;
  localparam logic [63:0] DAY = 64'd86400;
`ifdef ALARM_SNOOZE_EN
  localparam bit SNZ_ON = 1'b1;
`else
  localparam bit SNZ_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        tick_1hz;
  logic [63:0] counter;
  logic        alarm_set;
  logic [63:0] alarm_stamp;
  logic        alarm_en;
  logic        snooze;
  logic        dismiss;
  logic        ring;
  logic        armed;
  logic [63:0] target_stamp;
  logic [1:0]  snooze_cnt;

  always #5 clk = ~clk;

  alarm_scheduler #(.RING_SECS(RING), .SNOOZE_SECS(SNZ), .MAX_SNOOZE(MAXS)) dut (
    .clk          (clk),
    .rst          (rst),
    .tick_1hz     (tick_1hz),
    .counter      (counter),
    .alarm_set    (alarm_set),
    .alarm_stamp  (alarm_stamp),
    .alarm_en     (alarm_en),
    .snooze       (snooze),
    .dismiss      (dismiss),
    .ring         (ring),
    .armed        (armed),
    .target_stamp (target_stamp),
    .snooze_cnt   (snooze_cnt)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Behavioural model: what the alarm is doing, as independent flags.
  bit          m_ring, m_wait, m_snz, m_catch, m_en_prev;
  int          m_left, m_used;
  logic [63:0] m_target, m_snz_at;

  task automatic model_update();
    bit prev_en;
    if (rst) begin
      {m_ring, m_wait, m_snz, m_catch, m_en_prev} = '0;
      m_target = '0;
      m_used   = 0;
      return;
    end
    prev_en   = m_en_prev;
    m_en_prev = alarm_en;
    if (alarm_set) begin
      m_target = alarm_stamp;
      m_used   = 0;
      {m_ring, m_snz, m_catch} = '0;
      m_wait   = alarm_en;
    end else if (!alarm_en) begin
      {m_ring, m_wait, m_snz, m_catch} = '0;
    end else if (m_catch) begin
      m_used = 0;
      if (m_target <= counter) m_target = m_target + DAY;
      else begin m_catch = 0; m_wait = 1; end
    end else if (m_wait) begin
      if (counter >= m_target) begin m_wait = 0; m_ring = 1; m_left = RING; end
    end else if (m_snz) begin
      if (dismiss) begin m_snz = 0; m_catch = 1; end
      else if (counter >= m_snz_at) begin m_snz = 0; m_ring = 1; m_left = RING; end
    end else if (m_ring) begin
      if (tick_1hz) m_left--;
      if (dismiss || m_left <= 0) begin m_ring = 0; m_catch = 1; end
      else if (SNZ_ON && snooze && m_used < MAXS) begin
        m_used++;
        m_snz_at = counter + 64'(SNZ);
        m_ring = 0;
        m_snz  = 1;
      end
    end else begin
      if (alarm_en && !prev_en && m_target != 0) m_catch = 1;
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_update();
    #1;
    check("ring", ring, 64'(m_ring));
    check("armed", armed, 64'(m_wait || m_snz));
    check("target", target_stamp, m_target);
    check("snooze_cnt", 64'(snooze_cnt), 64'(m_used));
    alarm_set = 1'b0;
    snooze    = 1'b0;
    dismiss   = 1'b0;
    tick_1hz  = 1'b0;
  endtask

  task automatic tick_step();
    counter  = counter + 64'd1;
    tick_1hz = 1'b1;
    step();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick_step();
  endtask

  task automatic set_alarm(input logic [63:0] now, input logic [63:0] stamp);
    counter     = now;
    alarm_stamp = stamp;
    alarm_set   = 1'b1;
    step();
  endtask

  initial begin
    rst = 1'b1; tick_1hz = 1'b0; counter = '0; alarm_set = 1'b0; alarm_stamp = '0;
    alarm_en = 1'b0; snooze = 1'b0; dismiss = 1'b0;
    step();
    step();
    check("rst_ring", ring, 0);
    check("rst_armed", armed, 0);
    check("rst_target", target_stamp, 0);
    check("rst_snzcnt", 64'(snooze_cnt), 0);
    rst = 1'b0;
    alarm_en = 1'b1;

    // ring at 1000, full timeout, re-armed one day later
    set_alarm(64'd990, 64'd1000);
    check("t1_armed", armed, 1);
    ticks(9);
    check("t1_ring_before", ring, 0);
    tick_step();
    check("t1_ring_up", ring, 1);
    ticks(RING - 1);
    check("t1_ring_hold", ring, 1);
    tick_step();
    check("t1_ring_down", ring, 0);
    step();
    step();
    check("t1_target", target_stamp, 64'd87400);
    check("t1_rearmed", armed, 1);

    // dismiss at 1005
    set_alarm(64'd990, 64'd1000);
    ticks(15);
    check("t2_ringing", ring, 1);
    dismiss = 1'b1;
    step();
    check("t2_dismiss", ring, 0);
    step();
    step();
    check("t2_target", target_stamp, 64'd87400);

    // snooze at 1010
    set_alarm(64'd990, 64'd1000);
    ticks(20);
    snooze = 1'b1;
    step();
`ifdef ALARM_SNOOZE_EN
    check("t3_snz_ring", ring, 0);
    check("t3_snz_cnt", 64'(snooze_cnt), 1);
    ticks(SNZ - 1);
    check("t3_snz_quiet", ring, 0);
    tick_step();
    check("t3_snz_ring_again", ring, 1);
    snooze = 1'b1; step();
    ticks(SNZ);
    snooze = 1'b1; step();
    ticks(SNZ);
    check("t3_third_ring", ring, 1);
    check("t3_used3", 64'(snooze_cnt), 3);
    snooze = 1'b1;
    step();
    check("t3_4th_ignored", ring, 1);
    check("t3_cnt_hold", 64'(snooze_cnt), 3);
`else
    check("t3_snz_ignored", ring, 1);
    check("t3_cnt_tied", 64'(snooze_cnt), 0);
`endif
    dismiss = 1'b1;
    step();
    step();
    step();
    check("t3_target", target_stamp, 64'd87400);
    check("t3_cnt_clear", 64'(snooze_cnt), 0);

    // dismiss and snooze together
    set_alarm(64'd990, 64'd1000);
    ticks(12);
    dismiss = 1'b1;
    snooze  = 1'b1;
    step();
    check("t4_both_ring", ring, 0);
    step();
    step();
    check("t4_cnt", 64'(snooze_cnt), 0);
    check("t4_armed", armed, 1);

    // multi-day clock jump
    set_alarm(64'd990, 64'd1000);
    counter  = 64'd300000;
    tick_1hz = 1'b1;
    step();
    check("t5_ring", ring, 1);
    dismiss = 1'b1;
    step();
    repeat (4) step();
    check("t5_catchup_busy", armed, 0);
    check("t5_target4", target_stamp, 64'd346600);
    step();
    check("t5_armed", armed, 1);
    check("t5_target", target_stamp, 64'd346600);

    // reset mid-ring
    set_alarm(64'd990, 64'd1000);
    ticks(10);
    check("t6_ringing", ring, 1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("t6_rst_ring", ring, 0);
    check("t6_rst_armed", armed, 0);
    check("t6_rst_target", target_stamp, 0);

    // disable while snoozed (or ringing, without snooze)
    set_alarm(64'd990, 64'd1000);
    ticks(10);
    snooze = 1'b1;
    step();
    alarm_en = 1'b0;
    step();
    check("t7_dis_ring", ring, 0);
    check("t7_dis_armed", armed, 0);
    ticks(SNZ);
    check("t7_quiet", ring, 0);
    alarm_en = 1'b1;
    step();
    step();
    step();
    check("t7_reen_armed", armed, 1);
    check("t7_reen_target", target_stamp, 64'd87400);

    // random traffic
    counter = 64'd5000;
    for (int i = 0; i < 20000; i++) begin
      rst = ($urandom_range(0, 999) < 3);
      if ($urandom_range(0, 1) == 1) begin
        tick_1hz = 1'b1;
        counter  = counter + 64'd1;
      end
      if ($urandom_range(0, 999) < 2) counter = counter + 64'($urandom_range(0, 3 * 86400));
      if ($urandom_range(0, 299) == 0) begin
        alarm_set   = 1'b1;
        alarm_stamp = counter + 64'($urandom_range(1, 150));
      end
      if ($urandom_range(0, 499) == 0) alarm_en = ~alarm_en;
      snooze  = ($urandom_range(0, 39) == 0);
      dismiss = ($urandom_range(0, 149) == 0);
      step();
    end
    rst = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alarm_scheduler.md
# alarm_scheduler

- Sequences the daily alarm for the clock.
- Accepts a converted alarm timestamp (seconds since epoch, 64-bit, already pushed strictly into the future by the BCD→stamp converter) and compares it against the running seconds counter.
- Drives the ring output, handles dismiss, snooze and ring timeout, and re-arms the target one day later.
- Sits between the alarm-setting converter and the buzzer/display logic.

## Interface
Parameters:
- RING_SECS, 60: seconds the alarm rings before auto-dismiss.
- SNOOZE_SECS, 300: snooze interval in seconds.
- MAX_SNOOZE, 3: snoozes allowed per alarm event.

Ports:
- clk  in  1  system clock. One clock domain; reset is synchronous and active-high.
- rst  in  1  synchronous, active-high reset.
- tick_1hz  in  1  one-cycle pulse, coincident with each counter increment.
- counter  in  64  current time stamp in seconds.
- alarm_set  in  1  one-cycle pulse: load alarm_stamp as the new target.
- alarm_stamp  in  64  converted alarm time stamp.
- alarm_en  in  1  level; 0 disables the alarm.
- snooze  in  1  one-cycle pulse from the snooze key.
- dismiss  in  1  one-cycle pulse from the dismiss key.
- ring  out  1  level; high while the alarm sounds.
- armed  out  1  high in ARMED or SNOOZED.
- target_stamp  out  64  current daily target.
- snooze_cnt  out  2  snoozes used in the current event.

## Operation
States: IDLE, ARMED, RINGING, SNOOZED, CATCHUP.
- Reset → IDLE; ring=0, armed=0, target_stamp=0, snooze_cnt=0. Reset mid-ring silences on the next edge.
- alarm_set has highest priority in any state:
  - target_stamp ← alarm_stamp, snooze_cnt ← 0.
  - Next state is ARMED if alarm_en, else IDLE.
- alarm_en=0 (no alarm_set) forces IDLE from any state; target_stamp is retained.
- IDLE: alarm_en rising with a nonzero target → CATCHUP.
- ARMED: counter ≥ target_stamp → RINGING; ring timer ← RING_SECS.
- RINGING:
  - The timer decrements on tick_1hz.
  - dismiss, or the timer reaching 0 on a tick → CATCHUP.
  - snooze with snooze_cnt < MAX_SNOOZE:
    - snooze target ← counter + SNOOZE_SECS, snooze_cnt++.
    - → SNOOZED.
  - snooze at MAX_SNOOZE is ignored.
  - dismiss and snooze in the same cycle: dismiss wins.
- SNOOZED: counter ≥ snooze target → RINGING, timer reloaded; dismiss → CATCHUP.
- CATCHUP:
  - Each cycle, target_stamp ← target_stamp + 86400 while target_stamp ≤ counter; snooze_cnt ← 0.
  - When target_stamp > counter → ARMED. This covers clock jumps of multiple days.
- The daily target always advances from the original target, never from the snooze time.
- All additions are 64-bit unsigned; overflow is not handled, because the counter range makes it unreachable.
- target_stamp is not modified by snooze.

## Timing
- All outputs are registered.
- ring rises 1 cycle after the cycle in which counter ≥ target is sampled in ARMED/SNOOZED.
- ring falls 1 cycle after the dismiss/snooze/timeout cycle.
- Ring duration is exactly RING_SECS tick_1hz pulses.
- CATCHUP takes N+1 cycles for N day-increments. Input pulses other than alarm_set/alarm_en=0 are ignored while in CATCHUP.
- armed reflects the state register; it is 0 during RINGING and CATCHUP.

## Configuration
- ALARM_SNOOZE_EN defined: snooze behaviour as above; the SNOOZED state exists.
- ALARM_SNOOZE_EN undefined:
  - The snooze input is ignored and the SNOOZED state is not built.
  - snooze_cnt is tied to 0.
  - RINGING exits only by dismiss or timeout.

## Structure
- Shared package alarm_pkg holds:
  - the state enum;
  - SECS_PER_DAY = 64'd86400;
  - the 64-bit stamp typedef, shared with the BCD→stamp converter.
- One sub-module, alarm_sec_timer: loadable down-counter decremented on tick_1hz, with a zero flag. It is used for the ring timeout.
- The snooze compare uses a stored stamp, not a timer.

## Test plan
- alarm_set with stamp=1000, alarm_en=1, counter stepping from 990 → ring rises 1 cycle after counter=1000; 60 ticks later ring falls; target_stamp=87400; state ARMED.
- Ringing at counter=1005, dismiss pulse → ring=0 next cycle; target_stamp=87400.
- Ringing at counter=1010, snooze → snooze_cnt=1, ring=0; ring again at counter=1310. A 4th snooze, after 3 used, is ignored and the alarm keeps ringing.
- dismiss and snooze in the same cycle while ringing → dismiss wins; snooze_cnt=0 after CATCHUP.
- Armed target=1000, counter jumps to 300000 → rings; on dismiss, CATCHUP yields target_stamp=346600 after 4 increments.
- rst asserted mid-ring → ring=0, armed=0, target_stamp=0 next edge; alarm_en=0 while SNOOZED → IDLE, ring stays 0.
